// File: rtl/alu32_share_arbiter_pkg.sv
// alu32_arb_pkg: shared definitions for the ALU32 share arbiter.
//   - datapath/opcode widths and requester count
//   - ALU opcode values, shared with the ALU32 gate datapath top
//   - sequencer state encoding; SETTLE exists only when ALU_ARB_SETTLE_EN
//     is defined
//   - idx_onehot helper turning a requester index into a one-hot vector
package alu32_arb_pkg;

  localparam int WIDTH = 32;
  localparam int OPW   = 4;
  localparam int NREQ  = 2;
  localparam int IDXW  = 1;

  localparam logic [OPW-1:0] OP_AND = 4'd0;
  localparam logic [OPW-1:0] OP_OR  = 4'd1;
  localparam logic [OPW-1:0] OP_XOR = 4'd2;
  localparam logic [OPW-1:0] OP_ADD = 4'd3;
  localparam logic [OPW-1:0] OP_SUB = 4'd4;
  localparam logic [OPW-1:0] OP_SLT = 4'd5;

`ifdef ALU_ARB_SETTLE_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EVAL   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd3
  } state_t;
`endif

  function automatic logic [NREQ-1:0] idx_onehot(input logic [IDXW-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/alu32_share_arbiter_if.sv
// alu32_share_arbiter_if: bus bundle between the arbiter, its two
// requesters and the shared ALU32 gate datapath.
//   req_*    : per-requester request channel (packed, requester i in slice i)
//   rsp_*    : per-requester response channel, shared data/zero bus
//   alu_*    : registered operands to the ALU and its combinational result
// Handshake rule for both req and rsp channels: a transfer happens on a
// rising clock edge where valid and ready are both high for the same
// requester; valid must not depend on ready, and the producer holds its
// payload stable while valid is high and ready is low.
// modport slave  : the arbiter
// modport master : the environment (requesters plus ALU)
interface alu32_share_arbiter_if;
  import alu32_arb_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*OPW-1:0]   req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;

  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_zero;

  logic [OPW-1:0]        alu_op;
  logic [WIDTH-1:0]      alu_in1;
  logic [WIDTH-1:0]      alu_in2;
  logic [WIDTH-1:0]      alu_out;

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, rsp_zero, alu_op, alu_in1, alu_in2
  );

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, rsp_zero, alu_op, alu_in1, alu_in2
  );

endinterface

// File: rtl/alu32_share_arbiter_rr_pick.sv
// alu32_rr_pick: combinational 2-way round-robin picker.
//   valid : request valid vector (bit i = requester i)
//   last  : index of the requester served most recently
//   grant : one-hot grant, all-zero when nothing is valid
// On a tie the requester that was not served last wins.
module alu32_rr_pick
  import alu32_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == 1'b1) ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/alu32_share_arbiter.sv
// alu32_share_arbiter: time-shares one combinational 32-bit gate-level ALU
// between two requesters.
// Flow: IDLE picks a requester round-robin and registers its opcode and
// operands onto the ALU inputs; EVAL lets the ALU propagate; the result is
// captured and held on the response bus in RESP until the owner takes it.
// Optional feature macro: ALU_ARB_SETTLE_EN inserts a SETTLE state after
// EVAL and moves the capture to the end of SETTLE (two propagation cycles).
// Ports:
//   clk, rst_n  : clock (rising edge), synchronous active-low reset
//   bus         : alu32_share_arbiter_if.slave (request, response, ALU)
//   busy        : high in any state other than IDLE
//   dbg_state   : current sequencer state
//   dbg_last    : requester served most recently (round-robin pointer)
//   dbg_owner   : requester owning the operation in flight
module alu32_share_arbiter
  import alu32_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  alu32_share_arbiter_if.slave  bus,
  output logic                  busy,
  output state_t                dbg_state,
  output logic [IDXW-1:0]       dbg_last,
  output logic [IDXW-1:0]       dbg_owner
);

  state_t            state;
  logic [IDXW-1:0]   last;
  logic [IDXW-1:0]   owner;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   req_ready_c;
  logic              accept;
  logic [IDXW-1:0]   gidx;
  logic              rsp_hs;

  logic [OPW-1:0]    alu_op_q;
  logic [WIDTH-1:0]  alu_in1_q;
  logic [WIDTH-1:0]  alu_in2_q;
  logic [WIDTH-1:0]  rsp_data_q;
  logic              rsp_zero_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic              busy_q;

  alu32_rr_pick u_pick (
    .valid (bus.req_valid),
    .last  (last),
    .grant (grant)
  );

  // Ready is only offered in IDLE and never while reset is asserted, so a
  // request cannot slip in on the reset edge.
  assign req_ready_c = (rst_n && (state == ST_IDLE)) ? grant : '0;
  assign accept      = |(bus.req_valid & req_ready_c);
  assign gidx        = req_ready_c[1];
  // rsp_valid_q has only the owner bit set, so the non-owner's ready is
  // masked off here.
  assign rsp_hs      = |(rsp_valid_q & bus.rsp_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last        <= 1'b1;
      owner       <= '0;
      alu_op_q    <= '0;
      alu_in1_q   <= '0;
      alu_in2_q   <= '0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_op_q  <= gidx ? bus.req_op[2*OPW-1:OPW]   : bus.req_op[OPW-1:0];
            alu_in1_q <= gidx ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
            alu_in2_q <= gidx ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
            owner     <= gidx;
            busy_q    <= 1'b1;
            state     <= ST_EVAL;
          end
        end
`ifdef ALU_ARB_SETTLE_EN
        ST_EVAL: begin
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          rsp_data_q  <= bus.alu_out;
          rsp_zero_q  <= (bus.alu_out == '0);
          rsp_valid_q <= idx_onehot(owner);
          state       <= ST_RESP;
        end
`else
        ST_EVAL: begin
          rsp_data_q  <= bus.alu_out;
          rsp_zero_q  <= (bus.alu_out == '0);
          rsp_valid_q <= idx_onehot(owner);
          state       <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            last        <= owner;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= '0;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_in1   = alu_in1_q;
  assign bus.alu_in2   = alu_in2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = busy_q;
  assign dbg_state     = state;
  assign dbg_last      = last;
  assign dbg_owner     = owner;

endmodule

// File: tb/tb_alu32_share_arbiter.sv
// Bench for alu32_share_arbiter. Expected responses are hand-computed
// constants pushed into exp_q when a request is issued; a monitor pops and
// compares on every response handshake. The attached ALU model can delay
// its output by one cycle (alu_delay) to exercise ALU_ARB_SETTLE_EN.
module tb_alu32_share_arbiter;
  import alu32_arb_pkg::*;

  localparam int EW = NREQ + 1 + WIDTH;  // {rsp_valid, rsp_zero, rsp_data}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  state_t dbg_state;
  logic [IDXW-1:0] dbg_last;
  logic [IDXW-1:0] dbg_owner;
  bit alu_delay = 1'b0;
  logic [WIDTH-1:0] alu_q = '0;

  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  alu32_share_arbiter_if bus();

  alu32_share_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_last  (dbg_last),
    .dbg_owner (dbg_owner)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish (got timeout, want completion)");
    $fatal(1);
  end

  // ---------------- ALU model ----------------
  function automatic logic [WIDTH-1:0] alu_f(input logic [OPW-1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'b0, ($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) alu_q <= alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
  assign bus.alu_out = alu_delay ? alu_q : alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int r, input logic [WIDTH-1:0] data);
    logic [NREQ-1:0] v;
    v = (r == 1) ? 2'b10 : 2'b01;
    exp_q.push_back({v, (data == '0), data});
  endtask

  // Monitor: compares every response handshake against the queue head.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && ((bus.rsp_valid & bus.rsp_ready) != '0)) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {30'b0, bus.rsp_valid, bus.rsp_zero, bus.rsp_data}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 64'({bus.rsp_valid, bus.rsp_zero, bus.rsp_data}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int r, input logic [OPW-1:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_op[r*OPW +: OPW]     = op;
    bus.req_a[r*WIDTH +: WIDTH]  = a;
    bus.req_b[r*WIDTH +: WIDTH]  = b;
  endtask

  // Waits (bounded) for an accept, checks who got it, returns at posedge+1.
  task automatic wait_accept(input int r, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((bus.req_valid & bus.req_ready) != '0) got = 1'b1;
    end
    if (!got) check({name, "_timeout"}, 64'd0, 64'd1);
    else      check(name, 64'(bus.req_ready), (r == 1) ? 64'd2 : 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_single(input int r, input logic [OPW-1:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] exp_data, input string name);
    bus.rsp_ready = 2'b11;
    set_req(r, op, a, b);
    push_exp(r, exp_data);
    bus.req_valid = (r == 1) ? 2'b10 : 2'b01;
    wait_accept(r, name);
    bus.req_valid = 2'b00;
    wait_drain(name);
  endtask

  task automatic check_reset_vals(input string tag);
    @(negedge clk);
    check({tag, "_state"},    64'(dbg_state),     64'(ST_IDLE));
    check({tag, "_last"},     64'(dbg_last),      64'd1);
    check({tag, "_owner"},    64'(dbg_owner),     64'd0);
    check({tag, "_alu_op"},   64'(bus.alu_op),    64'd0);
    check({tag, "_alu_in1"},  64'(bus.alu_in1),   64'd0);
    check({tag, "_alu_in2"},  64'(bus.alu_in2),   64'd0);
    check({tag, "_rsp_data"}, 64'(bus.rsp_data),  64'd0);
    check({tag, "_rsp_zero"}, 64'(bus.rsp_zero),  64'd0);
    check({tag, "_rsp_valid"},64'(bus.rsp_valid), 64'd0);
    check({tag, "_busy"},     64'(busy),          64'd0);
  endtask

  // ---------------- tie-fairness vectors (hand-computed) ----------------
  logic [OPW-1:0]   t_op  [8] = '{OP_ADD, OP_SUB, OP_XOR, OP_SLT, OP_SLT, OP_ADD, OP_AND, OP_OR};
  logic [WIDTH-1:0] t_a   [8] = '{32'h0000_0001, 32'h0000_0005, 32'hFFFF_0000, 32'hFFFF_FFFF,
                                  32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000};
  logic [WIDTH-1:0] t_b   [8] = '{32'h0000_0002, 32'h0000_0007, 32'h0F0F_0F0F, 32'h0000_0001,
                                  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FFFF, 32'h0000_0001};
  logic [WIDTH-1:0] t_exp [8] = '{32'h0000_0003, 32'hFFFF_FFFE, 32'hF0F0_0F0F, 32'h0000_0001,
                                  32'h0000_0000, 32'h0000_0000, 32'h0000_5678, 32'h8000_0001};

  // ---------------- main stimulus ----------------
  initial begin
    bit seen;
    bus.req_valid = 2'b11;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 2'b00;

    // Reset with both requests pending: ready must stay low.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_forced", 64'(bus.req_ready), 64'd0);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    rst_n = 1'b1;
    check_reset_vals("por");

    // Single request with latency checks.
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    set_req(0, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    push_exp(0, 32'hF0F0_0F0F);
    bus.req_valid = 2'b01;
    wait_accept(0, "single_grant");
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("single_eval_valid", 64'(bus.rsp_valid), 64'd0);
    check("single_eval_busy",  64'(busy),          64'd1);
    check("single_alu_in1",    64'(bus.alu_in1),   64'hF0F0_0000);
`ifdef ALU_ARB_SETTLE_EN
    @(negedge clk);
    check("single_settle_valid", 64'(bus.rsp_valid), 64'd0);
`endif
    @(negedge clk);
    check("single_resp_valid", 64'(bus.rsp_valid), 64'd1);
    wait_drain("single");

    // Delayed ALU: correct with SETTLE, stale value without it.
    alu_delay = 1'b1;
`ifdef ALU_ARB_SETTLE_EN
    do_single(0, OP_ADD, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, "delay");
`else
    do_single(0, OP_ADD, 32'h0000_0100, 32'h0000_0023, 32'hF0F0_0F0F, "delay_stale");
`endif
    alu_delay = 1'b0;

    // Zero flag.
    do_single(1, OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, "zero");

    // Tie fairness: last served was requester 1, so 0 starts.
    bus.rsp_ready = 2'b11;
    set_req(0, t_op[0], t_a[0], t_b[0]);
    set_req(1, t_op[1], t_a[1], t_b[1]);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      push_exp(k % 2, t_exp[k]);
      wait_accept(k % 2, $sformatf("tie_grant%0d", k));
      if (k + 2 < 8) set_req(k % 2, t_op[k+2], t_a[k+2], t_b[k+2]);
    end
    bus.req_valid = 2'b00;
    wait_drain("tie");

    // Backpressure on requester 0; requester 1's ready must be ignored.
    bus.rsp_ready = 2'b10;
    set_req(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    push_exp(0, 32'h8000_0000);
    bus.req_valid = 2'b01;
    wait_accept(0, "bp_grant0");
    set_req(1, OP_XOR, 32'h0000_FFFF, 32'h0000_FF00);
    push_exp(1, 32'h0000_00FF);
    bus.req_valid = 2'b10;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) seen = 1'b1;
    end
    if (!seen) check("bp_resp_timeout", 64'd0, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp_hold_data",  64'(bus.rsp_data),  64'h8000_0000);
      check("bp_hold_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 2'b11;
    @(negedge clk);  // response handshake happens at the coming edge
    @(negedge clk);
    check("bp_r1_next", 64'(bus.req_ready), 64'd2);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    wait_drain("bp");

    // Serve requester 0 so the pointer points at 0 before the reset test.
    do_single(0, OP_XOR, 32'h0000_0003, 32'h0000_0005, 32'h0000_0006, "pre_rst");

    // Reset during EVAL: operation discarded, everything back to reset.
    set_req(1, OP_ADD, 32'h1111_1111, 32'h2222_2222);
    bus.req_valid = 2'b10;
    wait_accept(1, "mid_grant");
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset_vals("mid_rst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    // Next tie must go to requester 0 again.
    @(posedge clk); #1;
    set_req(0, OP_SUB, 32'h0000_0010, 32'h0000_0001);
    set_req(1, OP_AND, 32'hFFFF_FFFF, 32'h0F0F_0F0F);
    push_exp(0, 32'h0000_000F);
    push_exp(1, 32'h0F0F_0F0F);
    bus.req_valid = 2'b11;
    wait_accept(0, "post_rst_tie0");
    bus.req_valid = 2'b10;
    wait_accept(1, "post_rst_tie1");
    bus.req_valid = 2'b00;
    wait_drain("post_rst");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
